// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte producers. Each grant captures one byte, raises the UART
// enable until txBusy rises, waits for txBusy to fall, then idles for one
// GAP cycle so the UART always sees enable low for at least two cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   reqValid     per-requester byte pending (held until reqReady)
//   reqData      packed request bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqReady     one-hot, one-cycle accept pulse to the granted requester
//   txBusy       UART transmitter busy
//   enable       UART transmit enable
//   inputData    byte presented to the UART
//   grantId      index of the current/last granted requester
//   active       transfer in progress (FSM not idle)
//   timeoutFlag  one-cycle pulse on watchdog abort
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN adds a watchdog that aborts
// a transfer stuck in START/BUSY after TIMEOUT_CYCLES cycles. Without it
// timeoutFlag is tied low and START/BUSY wait indefinitely.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_REQ-1:0]                               reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                    reqData,
  output logic [NUM_REQ-1:0]                               reqReady,
  input  logic                                             txBusy,
  output logic                                             enable,
  output logic [DATA_WIDTH-1:0]                            inputData,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grantId,
  output logic                                             active,
  output logic                                             timeoutFlag
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter range checks
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_last;
  logic [ID_W-1:0]       r_grant;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]    r_ready;
  logic                  r_enable;
  logic                  r_active;

  logic                  w_found;
  logic                  w_upper;
  logic [ID_W-1:0]       w_winner;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NUM_REQ-1:0]    w_onehot;
  logic                  w_expire;

  // Round-robin pick: lowest requester above lastGrant, else lowest overall (wrap)
  always_comb begin
    w_found  = 1'b0;
    w_upper  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (reqValid[i] && !w_found) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (reqValid[i] && !w_upper && (i > int'(r_last))) begin
        w_upper  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
  end

  // Winner's byte and accept pulse
  always_comb begin
    w_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_winner == ID_W'(i)) begin
        w_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_onehot = NUM_REQ'(1) << w_winner;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;

  // Counter is zero on the first START cycle; expiry on the TIMEOUT_CYCLES-th cycle
  assign w_expire = ((r_state == S_START) || (r_state == S_BUSY)) &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_expire;
      if ((r_state == S_START) || (r_state == S_BUSY)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign timeoutFlag = r_tmo;
`else
  assign w_expire    = 1'b0;
  assign timeoutFlag = 1'b0;
`endif

  // Transfer sequencer with registered UART/requester outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_grant  <= '0;
      r_data   <= '0;
      r_ready  <= '0;
      r_enable <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_ready <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_data   <= w_data;
            r_grant  <= w_winner;
            r_last   <= w_winner;
            r_ready  <= w_onehot;
            r_enable <= 1'b1;
            r_active <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_expire) begin
            r_enable <= 1'b0;
            r_state  <= S_GAP;
          end else if (txBusy) begin
            r_enable <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_expire || !txBusy) begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign reqReady  = r_ready;
  assign enable    = r_enable;
  assign inputData = r_data;
  assign grantId   = r_grant;
  assign active    = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (default build, 4 requesters x 8 bits).
// Requester bytes and the round-robin winner come from a transaction-level
// reference model; the UART is modelled by driving txBusy per transfer.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic [NR-1:0] reqValid;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0] reqReady;
  logic          txBusy;
  logic          enable;
  logic [DW-1:0] inputData;
  logic [1:0]    grantId;
  logic          active;
  logic          timeoutFlag;

  int            n_chk;
  int            n_err;
  int            m_last;
  logic [7:0]    dat [4];

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .txBusy      (txBusy),
    .enable      (enable),
    .inputData   (inputData),
    .grantId     (grantId),
    .active      (active),
    .timeoutFlag (timeoutFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending requester after 'last', wrapping mod 4
  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx = (last + k) % 4;
      if (((m >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  // Reset for two cycles; outputs must already be at reset values one cycle in
  task automatic do_reset();
    reset    = 1'b1;
    reqValid = '0;
    @(negedge clk);
    check("rst_ready",  32'(reqReady),    32'd0);
    check("rst_enable", 32'(enable),      32'd0);
    check("rst_data",   32'(inputData),   32'd0);
    check("rst_grant",  32'(grantId),     32'd0);
    check("rst_active", 32'(active),      32'd0);
    check("rst_tmo",    32'(timeoutFlag), 32'd0);
    txBusy = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    m_last = 3;
  endtask

  // One complete transfer, entered and left at a negedge of an idle cycle
  task automatic xfer(input logic [3:0] mask, input bit pre_busy, input int start_dly,
                      input int busy_len, input bit scramble);
    int         win;
    logic [7:0] byte_q;
    reqValid = mask;
    reqData  = {dat[3], dat[2], dat[1], dat[0]};
    if (pre_busy) txBusy = 1'b1;
    win = rr_pick(mask, m_last);
    if (win < 0) win = 0;
    byte_q = dat[win];
    @(negedge clk);
    check("grant_ready", 32'(reqReady),    32'(4'b0001 << win));
    check("grant_id",    32'(grantId),     32'(win));
    check("grant_data",  32'(inputData),   32'(byte_q));
    check("start_en",    32'(enable),      32'd1);
    check("start_act",   32'(active),      32'd1);
    check("start_tmo",   32'(timeoutFlag), 32'd0);
    m_last = win;
    if (scramble) begin
      reqValid = 4'($urandom);
      reqData  = $urandom;
    end
    if (!pre_busy) begin
      for (int i = 0; i < start_dly; i++) begin
        @(negedge clk);
        check("start_hold_en", 32'(enable),    32'd1);
        check("ready_once",    32'(reqReady),  32'd0);
        check("start_data",    32'(inputData), 32'(byte_q));
      end
    end
    txBusy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      check("busy_en",    32'(enable),      32'd0);
      check("busy_act",   32'(active),      32'd1);
      check("busy_data",  32'(inputData),   32'(byte_q));
      check("busy_ready", 32'(reqReady),    32'd0);
      check("busy_tmo",   32'(timeoutFlag), 32'd0);
    end
    txBusy = 1'b0;
    @(negedge clk);
    check("gap_act", 32'(active), 32'd1);
    check("gap_en",  32'(enable), 32'd0);
    @(negedge clk);
    check("idle_act",   32'(active),   32'd0);
    check("idle_en",    32'(enable),   32'd0);
    check("idle_ready", 32'(reqReady), 32'd0);
  endtask

  initial begin
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    n_chk    = 0;
    n_err    = 0;
    m_last   = 3;
    reqValid = '0;
    reqData  = '0;
    txBusy   = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("idle_no_req", 32'(active), 32'd0);

    // Single byte from requester 0, UART busy for 20 cycles
    dat[0] = 8'hAA; dat[1] = 8'h00; dat[2] = 8'h00; dat[3] = 8'h00;
    xfer(4'b0001, 1'b0, 0, 20, 1'b0);

    // All four requesting continuously: strict rotation 0,1,2,3,0
    do_reset();
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    for (int k = 0; k < 5; k++) begin
      xfer(4'b1111, 1'b0, int'($urandom_range(0, 2)), 3, 1'b0);
      check("rr_seq", 32'(grantId), 32'(exp_seq[k]));
    end

    // Wrap: lastGrant=1, then 0101 grants 2 before 0
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    xfer(4'b0010, 1'b0, 1, 2, 1'b0);
    xfer(4'b0101, 1'b0, 0, 2, 1'b0);
    check("wrap_first", 32'(grantId), 32'd2);
    xfer(4'b0101, 1'b0, 0, 2, 1'b0);
    check("wrap_second", 32'(grantId), 32'd0);

    // Reset in the middle of BUSY abandons the byte; requester 1 is next
    reqValid = 4'b0100;
    reqData  = {dat[3], dat[2], dat[1], dat[0]};
    @(negedge clk);
    check("pre_rst_grant", 32'(reqReady), 32'b0100);
    txBusy = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(enable), 32'd0);
    do_reset();
    xfer(4'b0010, 1'b0, 0, 3, 1'b0);
    check("post_rst_grant", 32'(grantId), 32'd1);

    // txBusy already high on entry to START
    dat[3] = 8'h5C;
    xfer(4'b1000, 1'b1, 0, 4, 1'b0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      xfer(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        reqValid = '0;
        repeat (2) begin
          @(negedge clk);
          check("rand_idle_act",   32'(active),   32'd0);
          check("rand_idle_ready", 32'(reqReady), 32'd0);
        end
      end
    end

    // txBusy never rises: without the watchdog the transfer waits forever
    reqValid = 4'b0001;
    @(negedge clk);
    check("stuck_grant", 32'(reqReady), 32'b0001);
    reqValid = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("stuck_act", 32'(active),      32'd1);
      check("stuck_tmo", 32'(timeoutFlag), 32'd0);
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
